// File: rtl/sw_watch_cu.sv
// rtl/sw_watch_cu.sv - stopwatch/watch control unit: mode, stopwatch FSM, watch time-set FSM
// Optional decrement decode enabled by defining SW_WATCH_DEC_EN.
module sw_watch_cu #(
    parameter int N_FIELDS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_btn_mode,
    input  logic                i_btn_a,
    input  logic                i_btn_b,
    input  logic                i_btn_c,
    output logic                o_mode,
    output logic                o_run,
    output logic                o_clear,
    output logic                o_set_en,
    output logic [N_FIELDS-1:0] o_field,
    output logic                o_inc,
    output logic                o_dec
);

    localparam int IDX_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FIELDS - 1);

    typedef enum logic [1:0] {
        SW_STOP  = 2'd0,
        SW_RUN   = 2'd1,
        SW_CLEAR = 2'd2
    } sw_state_t;

    typedef enum logic {
        W_NORMAL = 1'b0,
        W_SET    = 1'b1
    } w_state_t;

    sw_state_t          sw_state, sw_next;
    w_state_t           w_state, w_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic               mode_next;
    logic               inc_next, dec_next;
    logic [N_FIELDS-1:0] field_next;

    // Priority-resolved button strobes: only one can be high per cycle.
    logic sel_mode, sel_a, sel_b, sel_c;

    assign sel_mode = i_btn_mode;
    assign sel_a    = i_btn_a & ~i_btn_mode;
    assign sel_b    = i_btn_b & ~i_btn_a & ~i_btn_mode;
`ifdef SW_WATCH_DEC_EN
    assign sel_c    = i_btn_c & ~i_btn_b & ~i_btn_a & ~i_btn_mode;
`else
    logic unused_btn_c;
    assign unused_btn_c = i_btn_c;
    assign sel_c        = 1'b0;
`endif

    always_comb begin
        mode_next = o_mode ^ sel_mode;
        sw_next   = sw_state;
        w_next    = w_state;
        idx_next  = idx;
        inc_next  = 1'b0;
        dec_next  = 1'b0;

        // Stopwatch keeps its state in watch mode; CLEAR always lasts one cycle.
        case (sw_state)
            SW_STOP: begin
                if (!o_mode && sel_a)
                    sw_next = SW_RUN;
                else if (!o_mode && sel_b)
                    sw_next = SW_CLEAR;
            end
            SW_RUN: begin
                if (!o_mode && sel_a)
                    sw_next = SW_STOP;
            end
            default: sw_next = SW_STOP;
        endcase

        if (sel_mode) begin
            w_next   = W_NORMAL;
            idx_next = '0;
        end else if (o_mode) begin
            case (w_state)
                W_NORMAL: begin
                    if (sel_a) begin
                        w_next   = W_SET;
                        idx_next = '0;
                    end
                end
                default: begin
                    if (sel_a) begin
                        if (idx == IDX_LAST) begin
                            w_next   = W_NORMAL;
                            idx_next = '0;
                        end else begin
                            idx_next = idx + 1'b1;
                        end
                    end else if (sel_b) begin
                        inc_next = 1'b1;
                    end else if (sel_c) begin
                        dec_next = 1'b1;
                    end
                end
            endcase
        end

        for (int i = 0; i < N_FIELDS; i++)
            field_next[i] = (w_next == W_SET) && (idx_next == IDX_W'(i));
    end

    // Outputs are flopped from next-state so every port is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_state <= SW_STOP;
            w_state  <= W_NORMAL;
            idx      <= '0;
            o_mode   <= 1'b0;
            o_run    <= 1'b0;
            o_clear  <= 1'b0;
            o_set_en <= 1'b0;
            o_field  <= '0;
            o_inc    <= 1'b0;
            o_dec    <= 1'b0;
        end else begin
            sw_state <= sw_next;
            w_state  <= w_next;
            idx      <= idx_next;
            o_mode   <= mode_next;
            o_run    <= (sw_next == SW_RUN);
            o_clear  <= (sw_next == SW_CLEAR);
            o_set_en <= (w_next == W_SET);
            o_field  <= field_next;
            o_inc    <= inc_next;
            o_dec    <= dec_next;
        end
    end

endmodule

// File: tb/tb_sw_watch_cu.sv
// tb/tb_sw_watch_cu.sv - directed self-checking bench for sw_watch_cu
module tb_sw_watch_cu;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode, btn_a, btn_b, btn_c;
    logic       mode, run, clear, set_en, inc, dec;
    logic [2:0] field;

    int n_checks = 0;
    int n_pass   = 0;

    sw_watch_cu #(.N_FIELDS(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_btn_mode (btn_mode),
        .i_btn_a    (btn_a),
        .i_btn_b    (btn_b),
        .i_btn_c    (btn_c),
        .o_mode     (mode),
        .o_run      (run),
        .o_clear    (clear),
        .o_set_en   (set_en),
        .o_field    (field),
        .o_inc      (inc),
        .o_dec      (dec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_all(input string tag, input logic e_mode, input logic e_run,
                              input logic e_clear, input logic e_set, input logic [2:0] e_field,
                              input logic e_inc, input logic e_dec);
        check({tag, ".mode"},  32'(mode),   32'(e_mode));
        check({tag, ".run"},   32'(run),    32'(e_run));
        check({tag, ".clear"}, 32'(clear),  32'(e_clear));
        check({tag, ".set"},   32'(set_en), 32'(e_set));
        check({tag, ".field"}, 32'(field),  32'(e_field));
        check({tag, ".inc"},   32'(inc),    32'(e_inc));
        check({tag, ".dec"},   32'(dec),    32'(e_dec));
    endtask

    // Drive buttons for one edge, then release; outputs are sampled 1 ns after that edge.
    task automatic step(input logic m, input logic a, input logic b, input logic c);
        btn_mode = m; btn_a = a; btn_b = b; btn_c = c;
        @(posedge clk);
        #1;
        btn_mode = 0; btn_a = 0; btn_b = 0; btn_c = 0;
    endtask

    initial begin
        logic exp_dec;
`ifdef SW_WATCH_DEC_EN
        exp_dec = 1'b1;
`else
        exp_dec = 1'b0;
`endif
        rst = 1; btn_mode = 0; btn_a = 0; btn_b = 0; btn_c = 0;
        @(negedge clk);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        expect_all("reset", 0, 0, 0, 0, 3'b000, 0, 0);
        rst = 0;

        step(0, 1, 0, 0); expect_all("a_run",    0, 1, 0, 0, 3'b000, 0, 0);
        step(0, 1, 0, 0); expect_all("a_stop",   0, 0, 0, 0, 3'b000, 0, 0);
        step(0, 0, 1, 0); expect_all("b_clear",  0, 0, 1, 0, 3'b000, 0, 0);
        step(0, 0, 0, 0); expect_all("clr_done", 0, 0, 0, 0, 3'b000, 0, 0);

        step(0, 1, 0, 0); expect_all("run2",     0, 1, 0, 0, 3'b000, 0, 0);
        step(0, 0, 1, 0); expect_all("run_b",    0, 1, 0, 0, 3'b000, 0, 0);
        step(1, 0, 0, 0); expect_all("to_watch", 1, 1, 0, 0, 3'b000, 0, 0);
        step(0, 0, 1, 0); expect_all("norm_b",   1, 1, 0, 0, 3'b000, 0, 0);

        step(0, 1, 0, 0); expect_all("fld0", 1, 1, 0, 1, 3'b001, 0, 0);
        step(0, 1, 0, 0); expect_all("fld1", 1, 1, 0, 1, 3'b010, 0, 0);
        step(0, 1, 0, 0); expect_all("fld2", 1, 1, 0, 1, 3'b100, 0, 0);
        step(0, 1, 0, 0); expect_all("wrap", 1, 1, 0, 0, 3'b000, 0, 0);

        step(0, 1, 0, 0);
        step(0, 1, 0, 0); expect_all("fld1b", 1, 1, 0, 1, 3'b010, 0, 0);
        step(0, 0, 1, 0); expect_all("inc1",  1, 1, 0, 1, 3'b010, 1, 0);
        step(0, 0, 1, 0); expect_all("inc2",  1, 1, 0, 1, 3'b010, 1, 0);
        step(0, 0, 1, 0); expect_all("inc3",  1, 1, 0, 1, 3'b010, 1, 0);
        step(0, 0, 0, 0); expect_all("inc_end", 1, 1, 0, 1, 3'b010, 0, 0);
        step(0, 0, 0, 1); expect_all("c_dec", 1, 1, 0, 1, 3'b010, 0, exp_dec);
        step(0, 0, 0, 0); expect_all("dec_end", 1, 1, 0, 1, 3'b010, 0, 0);
        step(0, 0, 1, 1); expect_all("bc_inc", 1, 1, 0, 1, 3'b010, 1, 0);

        step(0, 1, 1, 0); expect_all("ab_set", 1, 1, 0, 1, 3'b100, 0, 0);
        step(1, 0, 0, 0); expect_all("abort",  0, 1, 0, 0, 3'b000, 0, 0);
        step(0, 1, 0, 0); expect_all("stop3",  0, 0, 0, 0, 3'b000, 0, 0);
        step(1, 1, 0, 0); expect_all("mode_a", 1, 0, 0, 0, 3'b000, 0, 0);
        step(1, 0, 0, 0); expect_all("back_sw", 0, 0, 0, 0, 3'b000, 0, 0);

        step(0, 0, 1, 0); expect_all("clr2", 0, 0, 1, 0, 3'b000, 0, 0);
        rst = 1;
        step(0, 1, 0, 0); expect_all("rst_clr", 0, 0, 0, 0, 3'b000, 0, 0);
        rst = 0;
        step(0, 0, 0, 0); expect_all("post_rst1", 0, 0, 0, 0, 3'b000, 0, 0);

        step(1, 0, 0, 0);
        step(0, 1, 0, 0); expect_all("set_again", 1, 0, 0, 1, 3'b001, 0, 0);
        rst = 1;
        step(0, 1, 0, 0); expect_all("rst_set", 0, 0, 0, 0, 3'b000, 0, 0);
        rst = 0;
        step(0, 0, 0, 0); expect_all("post_rst2", 0, 0, 0, 0, 3'b000, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
